// File: rtl/iir_pkg.sv
// Shared definitions for the IIR filter chain: sample width and the
// occupancy-update encoding used by the output buffer.
package iir_pkg;

   // Sample width shared by the filter, the output buffer and the sink.
   localparam int NB = 12;

   // Occupancy update selected by the push/pop pair of a cycle.
   typedef enum logic [1:0] {
      OCC_HOLD = 2'd0,
      OCC_INC  = 2'd1,
      OCC_DEC  = 2'd2
   } occ_op_e;

   // Push alone grows the count, pop alone shrinks it, both or neither hold it.
   function automatic occ_op_e occ_op(input logic push, input logic pop);
      occ_op_e op;
      op = OCC_HOLD;
      if (push && !pop) begin
         op = OCC_INC;
      end else if (pop && !push) begin
         op = OCC_DEC;
      end
      return op;
   endfunction

endpackage

// File: rtl/iir_buf_mem.sv
// DEPTH x NB register array with one synchronous write port and one
// asynchronous read port. Contents are data only and carry no reset.
module iir_buf_mem #(
   parameter int NB    = 12,
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [AW-1:0]        waddr,
   input  logic signed [NB-1:0] wdata,
   input  logic [AW-1:0]        raddr,
   output logic signed [NB-1:0] rdata
);

   logic signed [NB-1:0] mem_q [DEPTH];
   logic signed [NB-1:0] mem_d [DEPTH];

   // Next array contents: the addressed entry takes the write data.
   always_comb begin
      mem_d = mem_q;
      if (we) begin
         mem_d[waddr] = wdata;
      end
   end

   // Storage registers, no reset since they only hold sample data.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/iir_out_buffer.sv
// Output-side elastic FIFO behind iir_filter: captures every valid sample,
// presents the head first-word-fall-through on a valid/ready interface,
// reports occupancy and keeps a sticky flag for samples dropped when full.
module iir_out_buffer #(
   parameter int  NB    = iir_pkg::NB,
   parameter int  DEPTH = 8,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic                 vIn,
   input  logic signed [NB-1:0] dIn,
   input  logic                 rdy,
   output logic                 vOut,
   output logic signed [NB-1:0] dOut,
   output logic [CW-1:0]        cnt,
   output logic                 full,
   output logic                 ovf
);

   import iir_pkg::occ_op_e;
   import iir_pkg::occ_op;
   import iir_pkg::OCC_INC;
   import iir_pkg::OCC_DEC;

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [AW-1:0]        wp_q, wp_d;
   logic [AW-1:0]        rp_q, rp_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 ovf_q, ovf_d;

   logic                 empty;
   logic                 is_full;
   logic                 push;
   logic                 pop;
   logic                 drop;
   occ_op_e              op;
   logic signed [NB-1:0] rd_data;

   // Status decoded from the registered count only, never from vIn/dIn.
   always_comb begin
      empty   = (cnt_q == '0);
      is_full = (cnt_q == CNT_FULL);
   end

   // Handshake enables: a full buffer still accepts when the head leaves.
   always_comb begin
      pop  = !empty && rdy;
      push = vIn && (!is_full || pop);
      drop = vIn && is_full && !pop;
      op   = occ_op(push, pop);
   end

   // Next-state for pointers, occupancy and the sticky drop flag; clr wins.
   always_comb begin
      wp_d  = wp_q;
      rp_d  = rp_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (clr) begin
         wp_d  = '0;
         rp_d  = '0;
         cnt_d = '0;
         ovf_d = 1'b0;
      end else begin
         if (push) begin
            wp_d = wp_q + PTR_ONE;
         end
         if (pop) begin
            rp_d = rp_q + PTR_ONE;
         end
         case (op)
            OCC_INC: cnt_d = cnt_q + CNT_ONE;
            OCC_DEC: cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
         endcase
         if (drop) begin
            ovf_d = 1'b1;
         end
      end
   end

   // Control registers; asynchronous reset discards any buffered samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   // The array is written on an accepted push; a flush write is harmless
   // because the pointers are cleared in the same cycle.
   iir_buf_mem #(
      .NB    (NB),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (push && !clr),
      .waddr (wp_q),
      .wdata (dIn),
      .raddr (rp_q),
      .rdata (rd_data)
   );

   // Head sample is forced to zero whenever the buffer is empty.
   always_comb begin
      vOut = !empty;
      dOut = empty ? '0 : rd_data;
      cnt  = cnt_q;
      full = is_full;
      ovf  = ovf_q;
   end

endmodule

// File: tb/tb_iir_out_buffer.sv
// Bench for iir_out_buffer: a queue scoreboard tracks every accepted sample
// and is checked each cycle, a vector table covers pass-through and
// fill/overflow/drain, and short sequences cover reset, wrap and flush.
module tb_iir_out_buffer;

   localparam int NB    = 12;
   localparam int DEPTH = 8;
   localparam int CW    = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          clr = 1'b0;
   logic          vin = 1'b0;
   logic [NB-1:0] din = '0;
   logic          rdy = 1'b0;
   logic          vout;
   logic [NB-1:0] dout;
   logic [CW-1:0] cnt;
   logic          full;
   logic          ovf;

   always #5 clk = ~clk;

   iir_out_buffer #(
      .NB    (NB),
      .DEPTH (DEPTH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .vIn   (vin),
      .dIn   (din),
      .rdy   (rdy),
      .vOut  (vout),
      .dOut  (dout),
      .cnt   (cnt),
      .full  (full),
      .ovf   (ovf)
   );

   int            n_chk  = 0;
   int            n_pass = 0;
   logic [NB-1:0] sb_q[$];
   logic          m_ovf = 1'b0;

   typedef struct {
      bit            rst;
      bit            v;
      logic [NB-1:0] d;
      bit            r;
      bit            c;
      int            ecnt;
      bit            evout;
      logic [NB-1:0] edout;
      bit            efull;
      bit            eovf;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic void add(input bit rs, input bit v, input logic [NB-1:0] d, input bit r,
                               input bit c, input int ecnt, input bit evout,
                               input logic [NB-1:0] edout, input bit efull, input bit eovf);
      vec_t t;
      t.rst = rs; t.v = v; t.d = d; t.r = r; t.c = c;
      t.ecnt = ecnt; t.evout = evout; t.edout = edout; t.efull = efull; t.eovf = eovf;
      vecs.push_back(t);
   endfunction

   // One clock: drive inputs, check outputs against the scoreboard, then
   // advance the scoreboard by what the edge should accept or drop.
   task automatic cycle(input bit v, input logic [NB-1:0] d, input bit r, input bit c);
      int            sz;
      bit            m_pop, m_push, m_full;
      logic [NB-1:0] head;
      vin = v; din = d; rdy = r; clr = c;
      sz = sb_q.size();
      chk("sb_cnt", 32'(cnt), 32'(sz));
      chk("sb_vout", 32'(vout), 32'(sz != 0));
      chk("sb_full", 32'(full), 32'(sz == DEPTH));
      chk("sb_ovf", 32'(ovf), 32'(m_ovf));
      if (sz == 0) chk("sb_dout_empty", 32'(dout), 32'(0));
      m_full = (sz == DEPTH);
      m_pop  = (sz > 0) && r;
      m_push = v && (!m_full || m_pop);
      if (m_pop && !c) begin
         head = sb_q.pop_front();
         chk("sb_data", 32'(dout), 32'(head));
      end
      @(posedge clk);
      #1;
      if (c) begin
         sb_q.delete();
         m_ovf = 1'b0;
      end else if (m_push) begin
         sb_q.push_back(d);
      end else if (v) begin
         m_ovf = 1'b1;
      end
   endtask

   // Reset asserted between edges; outputs must clear without a clock.
   task automatic do_reset();
      vin = 1'b0; din = '0; rdy = 1'b0; clr = 1'b0;
      rst_n = 1'b0;
      #2;
      chk("rst_cnt", 32'(cnt), 32'(0));
      chk("rst_vout", 32'(vout), 32'(0));
      chk("rst_dout", 32'(dout), 32'(0));
      chk("rst_ovf", 32'(ovf), 32'(0));
      chk("rst_full", 32'(full), 32'(0));
      sb_q.delete();
      m_ovf = 1'b0;
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [NB-1:0] last;
      int            sent;
      int            i;

      // Pass-through with rdy held high: each sample shows one cycle later.
      add(1, 1, 12'h7FF, 1, 0, 1, 1, 12'h7FF, 0, 0);
      add(0, 1, 12'h800, 1, 0, 1, 1, 12'h800, 0, 0);
      add(0, 1, 12'hFFF, 1, 0, 1, 1, 12'hFFF, 0, 0);
      add(0, 1, 12'h000, 1, 0, 1, 1, 12'h000, 0, 0);
      add(0, 0, 12'h000, 1, 0, 0, 0, 12'h000, 0, 0);
      // Fill with rdy low: full after the 8th, overflow on the 9th.
      for (int k = 1; k <= 9; k++)
         add(k == 1, 1, NB'(12'h100 + k), 0, 0, (k > 8) ? 8 : k, 1, 12'h101, k >= 8, k == 9);
      // Drain: 0x101..0x108 leave in order, 0x109 never appears.
      for (int k = 1; k <= 8; k++)
         add(0, 0, 12'h000, 1, 0, 8 - k, k < 8, (k < 8) ? NB'(12'h101 + k) : 12'h000, 0, 1);

      #1;
      do_reset();

      for (int n = 0; n < vecs.size(); n++) begin
         if (vecs[n].rst) do_reset();
         cycle(vecs[n].v, vecs[n].d, vecs[n].r, vecs[n].c);
         chk($sformatf("tbl%0d_cnt", n), 32'(cnt), 32'(vecs[n].ecnt));
         chk($sformatf("tbl%0d_vout", n), 32'(vout), 32'(vecs[n].evout));
         chk($sformatf("tbl%0d_dout", n), 32'(dout), 32'(vecs[n].edout));
         chk($sformatf("tbl%0d_full", n), 32'(full), 32'(vecs[n].efull));
         chk($sformatf("tbl%0d_ovf", n), 32'(ovf), 32'(vecs[n].eovf));
      end

      // Reset mid-stream: three buffered samples are lost.
      do_reset();
      cycle(1, 12'h001, 0, 0);
      cycle(1, 12'h002, 0, 0);
      cycle(1, 12'h003, 0, 0);
      chk("mid_cnt_pre", 32'(cnt), 32'(3));
      do_reset();
      for (int k = 0; k < 3; k++) cycle(0, 12'h000, 1, 0);
      chk("mid_vout_post", 32'(vout), 32'(0));

      // Full with simultaneous push and pop.
      do_reset();
      for (int k = 1; k <= 8; k++) cycle(1, NB'(k), 0, 0);
      chk("fs_full", 32'(full), 32'(1));
      cycle(1, 12'h0AA, 1, 0);
      chk("fs_cnt", 32'(cnt), 32'(8));
      chk("fs_ovf", 32'(ovf), 32'(0));
      last = '0;
      for (int k = 0; k < 8; k++) begin
         last = dout;
         cycle(0, 12'h000, 1, 0);
      end
      chk("fs_last", 32'(last), 32'(12'h0AA));
      chk("fs_empty", 32'(vout), 32'(0));

      // Pointer wrap: 20 samples, rdy toggling 1,0.
      do_reset();
      sent = 0;
      i = 0;
      while (sent < 20 && i < 200) begin
         cycle((i % 3) != 2, NB'($urandom), (i % 2) == 0, 0);
         if ((i % 3) != 2) sent++;
         i++;
      end
      chk("wrap_ovf", 32'(ovf), 32'(0));
      for (int k = 0; k < 10; k++) cycle(0, 12'h000, 1, 0);
      chk("wrap_drained", 32'(cnt), 32'(0));

      // Flush priority over push and pop with cnt 5 and ovf set.
      do_reset();
      for (int k = 1; k <= 9; k++) cycle(1, NB'(12'h100 + k), 0, 0);
      for (int k = 0; k < 3; k++) cycle(0, 12'h000, 1, 0);
      chk("fl_pre_cnt", 32'(cnt), 32'(5));
      chk("fl_pre_ovf", 32'(ovf), 32'(1));
      cycle(1, 12'h055, 1, 1);
      chk("fl_cnt", 32'(cnt), 32'(0));
      chk("fl_ovf", 32'(ovf), 32'(0));
      chk("fl_vout", 32'(vout), 32'(0));
      cycle(0, 12'h000, 1, 0);
      cycle(0, 12'h000, 1, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/iir_out_buffer.md
# iir_out_buffer

Output-side elastic buffer placed directly downstream of `iir_filter`. It captures every valid filtered sample (`vOut`/`dOut` of the filter) into a small FIFO and hands the samples to a consumer through a valid/ready handshake, so a stalling consumer loses nothing until the buffer fills. Occupancy is reported, and a sticky overflow flag records any sample dropped on a full buffer.

## Interface
- `NB`, 12, sample width; matches the filter data width.
- `DEPTH`, 8, number of entries; power of two, at least 2.
- `CW`, `$clog2(DEPTH)+1`, occupancy width; derived, not overridden.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `clr`  in  1  synchronous flush; empties the buffer and clears `ovf`.
- `vIn`  in  1  input sample valid; driven from the filter `vOut`.
- `dIn`  in  NB  input sample, two's complement; driven from the filter `dOut`.
- `rdy`  in  1  consumer ready.
- `vOut`  out  1  head sample valid; equals not-empty.
- `dOut`  out  NB  head sample; 0 when empty.
- `cnt`  out  CW  current occupancy, 0 to DEPTH.
- `full`  out  1  `cnt == DEPTH`.
- `ovf`  out  1  sticky; a sample was dropped.

## Operation
- **Storage:** DEPTH x NB register array with write pointer `wp` and read pointer `rp`. Each pointer is `$clog2(DEPTH)` bits and wraps naturally from DEPTH-1 to 0.
- **Push:** `push = vIn & (~full | pop)`. Writes `dIn` at `wp`, then increments `wp`.
- **Pop:** `pop = vOut & rdy`. Increments `rp`. Output is first-word-fall-through: `dOut = mem[rp]` while not empty.
- **Full with simultaneous pop:** the push is accepted and `cnt` is unchanged.
- **Full without pop:** the sample is dropped and `ovf` is set to 1. `ovf` stays at 1 until `clr` or reset.
- **Empty with `vIn`:** the sample is written. It is not bypassed; `vOut` stays 0 in that cycle.
- **Occupancy update:** `cnt` goes +1 on push only, -1 on pop only, and is unchanged on both or neither.
- **`clr`:** has priority over push and pop in the same cycle. It sets `wp`, `rp` and `cnt` to 0 and `ovf` to 0. The sample presented with `clr` is discarded and array contents are don't-care.
- **Reset (asynchronous, mid-operation included):** immediately forces `wp = rp = 0`, `cnt = 0`, `ovf = 0`, `vOut = 0`, `dOut = 0`, `full = 0`. Buffered samples are lost.
- **Data handling:** data is passed bit-exact; no arithmetic, sign handling or saturation is applied.

## Timing
- **Latency:** a sample pushed at edge k is visible on `vOut`/`dOut` immediately after edge k, so the consumer can take it at edge k+1. Minimum latency is 1 cycle.
- **Throughput:** one sample in and one out per cycle sustained, with `rdy` held at 1.
- **Output sources:**
  - `full` and `vOut` are decoded from the registered `cnt`.
  - `dOut` is a mux of registered storage.
  - No output depends combinationally on `vIn` or `dIn`.
- **`rdy` path:** `rdy` is combinationally qualified only into pop/push enables and never appears on an output.
- **`ovf`:** rises at the edge where the drop occurs.

## Structure
- **Shared package `iir_pkg`:** holds the sample-width constant `NB = 12`, so the filter, this buffer and the testbench `data_sink` agree on the width. `DEPTH` stays local to this block.
- **Sub-module:** one natural sub-module, `iir_buf_mem`, the DEPTH x NB register array with a write port and an asynchronous read port. Pointer, count and flag logic stay in `iir_out_buffer`.
- **Testbench integration:** the bench instantiates the buffer between `iir_filter` and `data_sink`. `data_sink` gains a `rdy` output that is pattern-driven.

## Test plan
- **Reset mid-stream:** push 3 samples (0x001, 0x002, 0x003), then pulse `rst_n` low between edges. Expect `cnt`, `vOut`, `dOut` and `ovf` at 0 immediately, and nothing popped after release.
- **Pass-through:** hold `rdy = 1` and stream 0x7FF, 0x800, 0xFFF, 0x000 on consecutive cycles. Expect each on `dOut` one cycle later in order, `cnt` at most 1, `ovf = 0`.
- **Fill and overflow:** hold `rdy = 0` and push 0x101 through 0x109 (9 samples). Expect `full = 1` after the 8th and `ovf = 1` after the 9th. Raising `rdy` then pops 0x101 through 0x108; 0x109 is absent.
- **Full with simultaneous push/pop:** fill with 0x001 through 0x008, then one cycle with `vIn = 1` (0x0AA) and `rdy = 1`. Expect `cnt` to remain 8, `ovf = 0`, and 0x0AA as the last sample drained.
- **Pointer wrap:** run 20 samples with `rdy` toggling 1,0,1,0. Expect no loss or reordering across pointer wrap, and `cnt` matching the scoreboard every cycle.
- **Flush priority:** with `cnt = 5` and `ovf = 1`, assert `clr` together with `vIn` (0x055) and `rdy`. Expect `cnt = 0`, `ovf = 0`, `vOut = 0` next cycle, and 0x055 discarded.
